// File: rtl/adc_block_averager.sv
// Block average/min/max/threshold of an unsigned sample stream; the results are read over OPB.
// Results, STATUS and BLOCK_CNT update one cycle after a block's last sample; there is no backpressure, so one sample per cycle is always accepted.
module adc_block_averager #(
    parameter int DATA_W   = 16,
    parameter int LOG2_MAX = 8
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST_N,
    input  logic              OPB_RE,
    input  logic              OPB_WE,
    input  logic [31:0]       OPB_ADDR,
    input  logic [31:0]       OPB_DI,
    output logic [31:0]       OPB_DO,
    input  logic              S_VALID,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              AVG_IRQ
);

    localparam int ACC_W = DATA_W + LOG2_MAX;
    localparam int CNT_W = LOG2_MAX + 1;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_LOG2   = 12'h002;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_AVG    = 12'h006;
    localparam logic [11:0] A_MIN    = 12'h008;
    localparam logic [11:0] A_MAX    = 12'h00A;
    localparam logic [11:0] A_THRESH = 12'h00C;
    localparam logic [11:0] A_BCNT   = 12'h00E;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_t;

    state_t            state_q, state_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic [3:0]        avg_log2_q, avg_log2_d;
    logic [3:0]        k_act_q, k_act_d;
    logic              result_valid_q, result_valid_d;
    logic              overrun_q, overrun_d;
    logic              over_thresh_q, over_thresh_d;
    logic [DATA_W-1:0] res_avg_q, res_avg_d;
    logic [DATA_W-1:0] res_min_q, res_min_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic [15:0]       block_cnt_q, block_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [31:0]       opb_do_q, opb_do_d;

    logic [11:0]       addr;
    logic              wr_ctrl, wr_log2, wr_status, wr_thresh, clear;
    logic              busy, fin, start_blk;
    logic [CNT_W-1:0]  blk_last;
    logic [DATA_W-1:0] avg_val;
    logic              unused_addr;

    assign addr        = OPB_ADDR[11:0];
    assign unused_addr = ^OPB_ADDR[31:12];
    assign wr_ctrl     = OPB_WE && (addr == A_CTRL);
    assign wr_log2     = OPB_WE && (addr == A_LOG2);
    assign wr_status   = OPB_WE && (addr == A_STATUS);
    assign wr_thresh   = OPB_WE && (addr == A_THRESH);
    assign clear       = wr_ctrl && OPB_DI[1];
    assign busy        = (state_q != S_IDLE);
    assign blk_last    = (CNT_W'(1) << k_act_q) - CNT_W'(1);
    assign avg_val     = DATA_W'(acc_q >> k_act_q);

    always_comb begin
        state_d        = state_q;
        enable_d       = enable_q;
        irq_en_d       = irq_en_q;
        avg_log2_d     = avg_log2_q;
        k_act_d        = k_act_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        over_thresh_d  = over_thresh_q;
        res_avg_d      = res_avg_q;
        res_min_d      = res_min_q;
        res_max_d      = res_max_q;
        thresh_d       = thresh_q;
        block_cnt_d    = block_cnt_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        min_d          = min_q;
        max_d          = max_q;
        opb_do_d       = opb_do_q;
        fin            = 1'b0;
        start_blk      = 1'b0;

        if (wr_ctrl) begin
            enable_d = OPB_DI[0];
            irq_en_d = OPB_DI[2];
        end
        if (wr_log2) begin
            avg_log2_d = (OPB_DI > 32'(LOG2_MAX)) ? 4'(LOG2_MAX) : OPB_DI[3:0];
        end
        if (wr_thresh) begin
            thresh_d = OPB_DI[DATA_W-1:0];
        end
        if (wr_status) begin
            result_valid_d = result_valid_q & ~OPB_DI[1];
            overrun_d      = overrun_q      & ~OPB_DI[2];
            over_thresh_d  = over_thresh_q  & ~OPB_DI[3];
        end

        case (state_q)
            S_IDLE: begin
                acc_d     = '0;
                cnt_d     = '0;
                min_d     = '1;
                max_d     = '0;
                start_blk = enable_q;
            end
            S_ACC: begin
                if (!enable_q) begin
                    state_d = S_IDLE;
                end else if (S_VALID) begin
                    acc_d = acc_q + ACC_W'(S_DATA);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (S_DATA < min_q) min_d = S_DATA;
                    if (S_DATA > max_q) max_d = S_DATA;
                    if (cnt_q == blk_last) state_d = S_FIN;
                end
            end
            S_FIN: begin
                fin       = 1'b1;
                state_d   = S_IDLE;
                start_blk = enable_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Status sets are applied after the W1C so a completing block always wins.
        if (fin) begin
            res_avg_d      = avg_val;
            res_min_d      = min_q;
            res_max_d      = max_q;
            block_cnt_d    = block_cnt_q + 16'd1;
            if (avg_val > thresh_q) over_thresh_d = 1'b1;
            if (result_valid_q)     overrun_d     = 1'b1;
            result_valid_d = 1'b1;
        end

        // A new block opens on the same cycle a sample may arrive, so that sample is its first.
        if (start_blk) begin
            k_act_d = avg_log2_q;
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            min_d   = '1;
            max_d   = '0;
            if (S_VALID) begin
                acc_d = ACC_W'(S_DATA);
                cnt_d = CNT_W'(1);
                min_d = S_DATA;
                max_d = S_DATA;
                if (avg_log2_q == 4'd0) state_d = S_FIN;
            end
        end

        if (clear) begin
            state_d        = S_IDLE;
            acc_d          = '0;
            cnt_d          = '0;
            min_d          = '1;
            max_d          = '0;
            result_valid_d = 1'b0;
            overrun_d      = 1'b0;
            over_thresh_d  = 1'b0;
            block_cnt_d    = 16'd0;
            res_avg_d      = res_avg_q;
            res_min_d      = res_min_q;
            res_max_d      = res_max_q;
        end

        if (OPB_RE) begin
            case (addr)
                A_CTRL:   opb_do_d = {29'd0, irq_en_q, 1'b0, enable_q};
                A_LOG2:   opb_do_d = 32'(avg_log2_q);
                A_STATUS: opb_do_d = {28'd0, over_thresh_q, overrun_q, result_valid_q, busy};
                A_AVG:    opb_do_d = 32'(res_avg_q);
                A_MIN:    opb_do_d = 32'(res_min_q);
                A_MAX:    opb_do_d = 32'(res_max_q);
                A_THRESH: opb_do_d = 32'(thresh_q);
                A_BCNT:   opb_do_d = 32'(block_cnt_q);
                default:  opb_do_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge OPB_CLK) begin
        if (!OPB_RST_N) begin
            state_q        <= S_IDLE;
            enable_q       <= 1'b0;
            irq_en_q       <= 1'b0;
            avg_log2_q     <= 4'd4;
            k_act_q        <= 4'd4;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            over_thresh_q  <= 1'b0;
            res_avg_q      <= '0;
            res_min_q      <= '0;
            res_max_q      <= '0;
            thresh_q       <= '1;
            block_cnt_q    <= 16'd0;
            acc_q          <= '0;
            cnt_q          <= '0;
            min_q          <= '1;
            max_q          <= '0;
            opb_do_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            enable_q       <= enable_d;
            irq_en_q       <= irq_en_d;
            avg_log2_q     <= avg_log2_d;
            k_act_q        <= k_act_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            over_thresh_q  <= over_thresh_d;
            res_avg_q      <= res_avg_d;
            res_min_q      <= res_min_d;
            res_max_q      <= res_max_d;
            thresh_q       <= thresh_d;
            block_cnt_q    <= block_cnt_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            min_q          <= min_d;
            max_q          <= max_d;
            opb_do_q       <= opb_do_d;
        end
    end

    assign OPB_DO  = opb_do_q;
    assign AVG_IRQ = irq_en_q & result_valid_q;

endmodule
